freq_meas_scheduler: RTL
========================

# freq_meas_scheduler

Round-robin scheduler that time-shares one period-measurement engine between `N_CH` pulse inputs. It selects a channel, flushes and re-arms the engine, and waits for a period result or a timeout. Each result is then presented, tagged with its channel, on a valid/ready result port. It sits between the board pulse inputs and the single period counter, so the design needs only one counter datapath.

## Interface
- `N_CH`, 4: number of pulse channels (2..16).
- `SETTLE_CYC`, 8: cycles the engine is held in clear after a mux switch. This must cover the engine's filter plus edge-detect depth (5).
- `TIMEOUT_CYC`, 25_000_000: maximum cycles in WAIT (250 ms at 100 MHz, more than 2 periods at 10 Hz).
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `run` in 1: scanning enabled. When it drops, the current channel completes, then the block goes idle.
- `ch_en` in N_CH: per-channel enable, sampled at each channel selection.
- `pulse_in` in N_CH: raw pulse inputs.
- `meas_pulse` out 1: `pulse_in[cur_ch]`. Forced 0 outside SETTLE/ARM/WAIT.
- `meas_clr` out 1: engine synchronous clear.
- `meas_start` out 1: one-cycle arm strobe to the engine.
- `eng_valid` in 1: engine result strobe.
- `eng_period` in 32: engine period count, in clk cycles.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_ch` out clog2(N_CH): channel of the result.
- `res_period` out 32: measured period, or 0 on timeout.
- `res_timeout` out 1: no complete period was seen within `TIMEOUT_CYC`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, SELECT, SETTLE, ARM, WAIT, REPORT.
- **IDLE**
  - If `run && |ch_en`, go to SELECT.
  - The round-robin pointer holds its value across IDLE.
- **SELECT** (1 cycle)
  - `cur_ch` is set to the first enabled channel strictly after the last serviced channel, wrapping modulo `N_CH`.
  - After reset, the last serviced channel is `N_CH-1`, so channel 0 is searched first.
  - If only one channel is enabled, it is reselected.
  - `meas_clr` = 1. Go to SETTLE.
- **SETTLE**
  - `meas_clr` = 1 for `SETTLE_CYC` cycles, then go to ARM.
- **ARM** (1 cycle)
  - `meas_clr` = 0, `meas_start` = 1.
  - Clear the timeout counter. Go to WAIT.
- **WAIT**
  - The timeout counter increments every cycle.
  - On `eng_valid`: capture `eng_period`, set `res_timeout` = 0, go to REPORT.
  - Else, when the counter reaches `TIMEOUT_CYC-1`: set `res_period` = 0, `res_timeout` = 1, go to REPORT.
  - If both happen in the same cycle, `eng_valid` wins.
- **REPORT**
  - `res_valid` = 1. `res_ch`, `res_period` and `res_timeout` stay stable until the handshake completes.
  - On `res_valid && res_ready`: update the last-serviced pointer to `cur_ch`.
  - Then go to SELECT if `run && |ch_en`, else to IDLE.
- `eng_valid` is ignored in every state except WAIT.
- `ch_en` changes take effect only at the next SELECT. A channel disabled during WAIT still completes and reports.
- `rst` asserted in any state forces IDLE on the next edge and abandons any pending result.
- Reset values of all outputs:
  - `meas_pulse`, `meas_clr`, `meas_start`, `res_valid`, `res_timeout`, `busy` = 0.
  - `res_ch` = 0, `res_period` = 0.

## Timing
- Fixed overhead from leaving IDLE or REPORT to the `meas_start` strobe is 1 + `SETTLE_CYC` + 1 cycles:
  - SELECT at cycle t.
  - SETTLE at t+1 .. t+SETTLE_CYC.
  - ARM at t+SETTLE_CYC+1.
- `res_valid` rises on the cycle after `eng_valid` is sampled in WAIT, or after the timeout compare hits.
- Back-to-back: when `res_ready` is held at 1, REPORT lasts 1 cycle and SELECT follows immediately.
- All outputs are registered except `meas_pulse`, which is a combinational mux of the selected input gated by state.
- The timeout counter is 32 bits wide and does not wrap, because WAIT exits at `TIMEOUT_CYC-1`.

## Structure
- The shared package `cymo_pkg` holds:
  - state encoding (one-hot, 6 bits);
  - `PERIOD_W` = 32;
  - default `CLK_HZ` = 100_000_000;
  - default `TIMEOUT_CYC`.
- Sub-module `rr_pick`: a combinational round-robin next-enabled-channel finder.
  - Inputs: `en[N_CH]`, `last[clog2]`.
  - Outputs: `next[clog2]`, `any`.
- The top level is the FSM, the counters and the result registers only.

## Test plan
- **Single channel.** `ch_en`=0001, `run`=1, 1 kHz pulse on channel 0, engine model returns 100000 → result `res_ch`=0, `res_period`=100000, `res_timeout`=0. Also check that `meas_start` occurs exactly `SETTLE_CYC`+2 cycles after `run` rises.
- **Round robin.** `ch_en`=1011, `res_ready`=1 → results arrive in channel order 0, 1, 3, 0, 1, 3, and channel 2's pulses never reach `meas_pulse`.
- **Timeout.** Channel 1 is held at constant 0 with `TIMEOUT_CYC`=1000 → after 1000 WAIT cycles, `res_ch`=1, `res_period`=0, `res_timeout`=1, then the scan proceeds to the next channel.
- **Backpressure and collision.**
  - Hold `res_ready`=0 for 50 cycles in REPORT → outputs stay stable and no new `meas_start` is issued.
  - Separately, `eng_valid` in the same cycle as the timeout hit → `res_timeout`=0 and the period is captured.
- **Control changes.**
  - Drop `run` during WAIT → the current result is reported, then IDLE with `busy`=0.
  - Assert `rst` during SETTLE → all outputs go to reset values on the next cycle, and the next scan starts at channel 0.

Source files
------------

// File: rtl/cymo_pkg.sv
// Shared definitions for the period-measurement scheduler: state encoding,
// datapath width and default timing constants.
package cymo_pkg;

  localparam int PERIOD_W        = 32;
  localparam int CLK_HZ          = 100_000_000;
  // 250 ms window, long enough for two full periods of a 10 Hz input
  localparam int DEF_TIMEOUT_CYC = CLK_HZ / 4;

  // state     | meaning
  // ST_IDLE   | scanning stopped, round-robin pointer held
  // ST_SELECT | pick next enabled channel, engine held in clear
  // ST_SETTLE | engine held in clear while the new input propagates
  // ST_ARM    | one-cycle start strobe to the engine
  // ST_WAIT   | waiting for a period result or the timeout
  // ST_REPORT | result presented until the consumer accepts it
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SELECT = 6'b000010,
    ST_SETTLE = 6'b000100,
    ST_ARM    = 6'b001000,
    ST_WAIT   = 6'b010000,
    ST_REPORT = 6'b100000
  } state_t;

  // Channel index width, never below one bit
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_meas_scheduler_if.sv
// Result port of the scheduler: valid/ready handshake carrying the channel
// tag, the measured period and the timeout flag.
interface freq_meas_scheduler_if
  import cymo_pkg::*;
#(
  parameter int N_CH = 4
) ();

  localparam int CH_W = ch_width(N_CH);

  logic                res_valid;
  logic                res_ready;
  logic [CH_W-1:0]     res_ch;
  logic [PERIOD_W-1:0] res_period;
  logic                res_timeout;

  modport master (
    output res_valid,
    output res_ch,
    output res_period,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_ch,
    input  res_period,
    input  res_timeout,
    output res_ready
  );

endinterface

// File: rtl/freq_meas_scheduler_rr_pick.sv
// Round-robin finder: returns the first enabled channel strictly after
// i_last, wrapping around. With a single enabled channel that channel is
// returned even when it equals i_last.
module rr_pick
  import cymo_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] i_en,
  input  logic [CH_W-1:0] i_last,
  output logic [CH_W-1:0] o_next,
  output logic            o_any
);

  // Scan from the farthest offset down so the nearest enabled channel wins
  always_comb begin
    o_next = i_last;
    for (int k = N_CH; k >= 1; k--) begin
      if (i_en[(int'(i_last) + k) % N_CH]) begin
        o_next = CH_W'((int'(i_last) + k) % N_CH);
      end
    end
  end

  assign o_any = |i_en;

endmodule

// File: rtl/freq_meas_scheduler.sv
// Time-shares one period-measurement engine between N_CH pulse inputs.
// Each pass selects a channel, holds the engine in clear while the mux
// settles, arms it, waits for a period or a timeout, then presents the
// tagged result on the valid/ready port.
module freq_meas_scheduler
  import cymo_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic [N_CH-1:0]       i_ch_en,
  input  logic [N_CH-1:0]       i_pulse_in,
  output logic                  o_meas_pulse,
  output logic                  o_meas_clr,
  output logic                  o_meas_start,
  input  logic                  i_eng_valid,
  input  logic [PERIOD_W-1:0]   i_eng_period,
  output logic                  o_busy,
  freq_meas_scheduler_if.master res_if
);

  localparam int                CH_W     = ch_width(N_CH);
  localparam int                SET_W    = $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

  state_t              r_state;
  logic [CH_W-1:0]     r_cur_ch;
  logic [CH_W-1:0]     r_last;
  logic [SET_W-1:0]    r_settle_cnt;
  logic [31:0]         r_to_cnt;
  logic                r_meas_clr;
  logic                r_meas_start;
  logic                r_busy;
  logic                r_res_valid;
  logic [CH_W-1:0]     r_res_ch;
  logic [PERIOD_W-1:0] r_res_period;
  logic                r_res_timeout;

  logic [CH_W-1:0]     w_next;
  logic                w_any;
  logic                w_scan_req;
  logic                w_meas_win;

  assign w_scan_req = i_run && (|i_ch_en);

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .i_en   (i_ch_en),
    .i_last (r_last),
    .o_next (w_next),
    .o_any  (w_any)
  );

  // Sequencer: state, settle/timeout counters and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cur_ch      <= '0;
      r_last        <= CH_LAST;
      r_settle_cnt  <= '0;
      r_to_cnt      <= '0;
      r_meas_clr    <= 1'b0;
      r_meas_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_ch      <= '0;
      r_res_period  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_meas_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_scan_req) begin
            r_state    <= ST_SELECT;
            r_meas_clr <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (w_any) begin
            r_cur_ch     <= w_next;
            r_settle_cnt <= SET_LOAD;
            r_state      <= ST_SETTLE;
          end else begin
            // every channel was disabled between IDLE/REPORT and now
            r_state    <= ST_IDLE;
            r_meas_clr <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_state      <= ST_ARM;
            r_meas_clr   <= 1'b0;
            r_meas_start <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        ST_ARM: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // an engine result in the timeout cycle still counts as a result
          if (i_eng_valid) begin
            r_res_period  <= i_eng_period;
            r_res_timeout <= 1'b0;
            r_res_ch      <= r_cur_ch;
            r_res_valid   <= 1'b1;
            r_state       <= ST_REPORT;
          end else if (r_to_cnt == TO_LAST) begin
            r_res_period  <= '0;
            r_res_timeout <= 1'b1;
            r_res_ch      <= r_cur_ch;
            r_res_valid   <= 1'b1;
            r_state       <= ST_REPORT;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        ST_REPORT: begin
          if (res_if.res_ready) begin
            r_res_valid <= 1'b0;
            r_last      <= r_cur_ch;
            if (w_scan_req) begin
              r_state    <= ST_SELECT;
              r_meas_clr <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_meas_clr   <= 1'b0;
          r_busy       <= 1'b0;
          r_res_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Engine input is only live while the selected channel is being measured
  assign w_meas_win   = (r_state == ST_SETTLE) || (r_state == ST_ARM) ||
                        (r_state == ST_WAIT);
  assign o_meas_pulse = w_meas_win & i_pulse_in[r_cur_ch];

  assign o_meas_clr   = r_meas_clr;
  assign o_meas_start = r_meas_start;
  assign o_busy       = r_busy;

  assign res_if.res_valid   = r_res_valid;
  assign res_if.res_ch      = r_res_ch;
  assign res_if.res_period  = r_res_period;
  assign res_if.res_timeout = r_res_timeout;

endmodule
